alu_seq: RTL

//   Parametrised, registered ALU for the calculator datapath; successor to the 8-bit ripple ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 99 +++++++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state and flag types for the alu_seq calculator ALU.
// The divide op is only decoded when ALU_DIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic div_by_zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add unsigned multiply, plus restoring unsigned divide
// when ALU_DIV_EN is defined. One bit per cycle, WIDTH cycles per operation.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
`ifdef ALU_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   div_shift, div_trial;
`endif

    // hi_q:lo_q is the product accumulator (MUL) or remainder:quotient (DIV).
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
`ifdef ALU_DIV_EN
        is_div_d  = is_div_q;
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
`endif
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH);
            opnd_d = b_i;
            hi_d   = '0;
            lo_d   = a_i;
`ifdef ALU_DIV_EN
            is_div_d = is_div_i;
`endif
        end else if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
`ifdef ALU_DIV_EN
            if (is_div_q) begin
                hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
            end else
`endif
            begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
`ifdef ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    // Final step's next values are presented so the top can register them directly.
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with valid/ready on both sides and iterative MUL/DIV.
// Define ALU_DIV_EN to build the unsigned divider; otherwise op 1001 is an unknown op.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             div_by_zero,
    output alu_state_e       dbg_state
);

    // Handshake: an operation is accepted on a rising edge where in_valid && in_ready;
    // a result is consumed on a rising edge where out_valid && out_ready. in_ready is
    // high only in IDLE, out_valid only in DONE, so at most one operation is in flight.

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    alu_flags_t       flags_q, flags_d;

    logic [WIDTH-1:0] c_res, c_hi;
    alu_flags_t       c_flags;
    logic             c_known, iter_op;
    logic [WIDTH:0]   add_sum, sub_sum;

    logic             eng_start, eng_done;
    logic [WIDTH-1:0] eng_lo, eng_hi;

    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + 1'b1;
        c_res   = '0;
        c_hi    = '0;
        c_flags = '0;
        c_known = 1'b1;
        iter_op = 1'b0;
        case (op)
            OP_AND: c_res = a & b;
            OP_OR:  c_res = a | b;
            OP_NOR: c_res = ~(a | b);
            OP_ADD: begin
                c_res            = add_sum[WIDTH-1:0];
                c_flags.carry    = add_sum[WIDTH];
                c_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_res            = sub_sum[WIDTH-1:0];
                c_flags.carry    = sub_sum[WIDTH];
                c_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: c_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_MUL: iter_op = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (b == '0) begin
                    c_res               = '1;
                    c_hi                = a;
                    c_flags.div_by_zero = 1'b1;
                end else begin
                    iter_op = 1'b1;
                end
            end
`endif
            default: c_known = 1'b0;
        endcase
        c_flags.zero = c_known && (c_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        hi_d      = hi_q;
        flags_d   = flags_q;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (iter_op) begin
                        eng_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        res_d   = c_res;
                        hi_d    = c_hi;
                        flags_d = c_flags;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (eng_done) begin
                    res_d            = eng_lo;
                    hi_d             = eng_hi;
                    flags_d          = '0;
                    flags_d.zero     = (eng_lo == '0);
                    flags_d.overflow = (op_q == OP_MUL) && (eng_hi != '0);
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (eng_start),
`ifdef ALU_DIV_EN
        .is_div_i(op == OP_DIV),
`endif
        .a_i     (a),
        .b_i     (b),
        .done_o  (eng_done),
        .lo_o    (eng_lo),
        .hi_o    (eng_hi)
    );

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = res_q;
    assign result_hi   = hi_q;
    assign zero        = flags_q.zero;
    assign carry_out   = flags_q.carry;
    assign overflow    = flags_q.overflow;
    assign div_by_zero = flags_q.div_by_zero;
    assign dbg_state   = state_q;

endmodule
